// File: rtl/sync_fifo_prefetch_param.sv
// Synchronous FIFO: sync-read array behind a two-stage prefetch pipeline (first-word-fall-through).
// Latency: a write into an empty FIFO at edge t shows on rd_data after edge t+2; pops run at one word per cycle.
// Backpressure: wr_vld drops when 2^DEPTH_WIDTH words are held; rd_en is ignored while rd_vld=0.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   wr_en, wr_data    write request and word; accepted when wr_vld=1
//   wr_vld            FIFO can accept a write this cycle
//   rd_en             pop the word on rd_data; effective when rd_vld=1
//   rd_vld, rd_data   head word valid and head word
//   level             words held across array, prefetch stage and output register
//   almost_full       level >= AF_LEVEL
//   almost_empty      level <= AE_LEVEL
//   err_clr           clears overflow/underflow
//   overflow          sticky: write attempted while full
//   underflow         sticky: pop attempted while empty
//   par_err           (SYNC_FIFO_PF_PARITY_EN only) one-cycle pulse when a bad-parity word loads the output register
//
// Build option: define SYNC_FIFO_PF_PARITY_EN to store an even-parity bit per word and expose par_err.
module sync_fifo_prefetch_param #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH_WIDTH = 11,
  parameter int AF_LEVEL    = 2040,
  parameter int AE_LEVEL    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   wr_vld,
  input  logic                   rd_en,
  output logic                   rd_vld,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic [DEPTH_WIDTH:0]   level,
  output logic                   almost_full,
  output logic                   almost_empty,
  input  logic                   err_clr,
  output logic                   overflow,
`ifdef SYNC_FIFO_PF_PARITY_EN
  output logic                   underflow,
  output logic                   par_err
`else
  output logic                   underflow
`endif
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] DEPTH_L = (DEPTH_WIDTH+1)'(DEPTH);
  localparam logic [DEPTH_WIDTH:0] AF_L    = (DEPTH_WIDTH+1)'(AF_LEVEL);
  localparam logic [DEPTH_WIDTH:0] AE_L    = (DEPTH_WIDTH+1)'(AE_LEVEL);

`ifdef SYNC_FIFO_PF_PARITY_EN
  localparam int MW = DATA_WIDTH + 1;
`else
  localparam int MW = DATA_WIDTH;
`endif

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // no head word anywhere in the pipeline
    ST_FETCH = 2'd1,  // array read landed in the prefetch stage, output register still empty
    ST_VALID = 2'd2   // head word sits in the output register
  } state_t;

  state_t                 state;
  logic [MW-1:0]          mem [0:DEPTH-1];
  logic [MW-1:0]          mem_q;      // synchronous-read data = prefetch stage
  logic                   s1_vld;     // prefetch stage holds a word
  logic [MW-1:0]          wr_word;
  logic [DEPTH_WIDTH-1:0] wr_ptr;
  logic [DEPTH_WIDTH-1:0] rd_ptr;
  logic [DEPTH_WIDTH:0]   arr_cnt;    // words still in the array (not yet read out)
  logic                   wr_acc;
  logic                   pop;
  logic                   s2_load;
  logic                   rd_issue;

`ifdef SYNC_FIFO_PF_PARITY_EN
  assign wr_word = {^wr_data, wr_data};
`else
  assign wr_word = wr_data;
`endif

  assign wr_vld       = (level < DEPTH_L);
  assign wr_acc       = wr_en & wr_vld;
  assign pop          = rd_en & rd_vld;
  assign almost_full  = (level >= AF_L);
  assign almost_empty = (level <= AE_L);

  // Output register refills from the prefetch stage whenever it is empty or being popped.
  assign s2_load  = s1_vld & (~rd_vld | pop);
  // The prefetch stage reads the array whenever it is empty or handing its word on in the
  // same edge; this keeps one word in flight ahead of the head so back-to-back pops never
  // see an rd_vld gap.
  assign rd_issue = (arr_cnt != '0) & (~s1_vld | s2_load);

  // Array storage and synchronous read port; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_word;
    end
    if (rd_issue) begin
      mem_q <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      rd_vld    <= 1'b0;
      s1_vld    <= 1'b0;
      rd_data   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      arr_cnt   <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (rd_issue) begin
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // The prefetch stage is full here, so the output register loads this edge.
          state  <= ST_VALID;
          rd_vld <= 1'b1;
        end
        ST_VALID: begin
          if (pop && !s1_vld) begin
            rd_vld <= 1'b0;
            if (rd_issue) begin
              state <= ST_FETCH;
            end else begin
              state <= ST_EMPTY;
            end
          end
        end
        default: begin
          state  <= ST_EMPTY;
          rd_vld <= 1'b0;
        end
      endcase

      s1_vld <= rd_issue | (s1_vld & ~s2_load);

      if (s2_load) begin
        rd_data <= mem_q[DATA_WIDTH-1:0];
      end

      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_issue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({wr_acc, rd_issue})
        2'b10:   arr_cnt <= arr_cnt + 1'b1;
        2'b01:   arr_cnt <= arr_cnt - 1'b1;
        default: arr_cnt <= arr_cnt;
      endcase

      case ({wr_acc, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      // Set wins over clear in the same cycle.
      if (wr_en && !wr_vld) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end

      if (rd_en && !rd_vld) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end

`ifdef SYNC_FIFO_PF_PARITY_EN
  // Even parity over data+parity bit: an odd XOR means the stored word is corrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err <= 1'b0;
    end else begin
      par_err <= s2_load & (^mem_q);
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_prefetch_param.sv
// Scoreboard bench for sync_fifo_prefetch_param with default parameters (8-bit, 2048 words).
module tb_sync_fifo_prefetch_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_vld;
  logic        rd_en = 1'b0;
  logic        rd_vld;
  logic [7:0]  rd_data;
  logic [11:0] level;
  logic        almost_full;
  logic        almost_empty;
  logic        err_clr = 1'b0;
  logic        overflow;
  logic        underflow;
`ifdef SYNC_FIFO_PF_PARITY_EN
  logic        par_err;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  sync_fifo_prefetch_param dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wr_vld       (wr_vld),
    .rd_en        (rd_en),
    .rd_vld       (rd_vld),
    .rd_data      (rd_data),
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .err_clr      (err_clr),
    .overflow     (overflow),
`ifdef SYNC_FIFO_PF_PARITY_EN
    .underflow    (underflow),
    .par_err      (par_err)
`else
    .underflow    (underflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a write for the coming edge; the word is expected only if the FIFO accepts it.
  task automatic drive_wr(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    if (wr_vld) sb.push_back(d);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_vld"}, int'(wr_vld), 1);
    check({tag, "_rd_vld"}, int'(rd_vld), 0);
    check({tag, "_rd_data"}, int'(rd_data), 0);
    check({tag, "_level"}, int'(level), 0);
    check({tag, "_af"}, int'(almost_full), 0);
    check({tag, "_ae"}, int'(almost_empty), 1);
    check({tag, "_ovf"}, int'(overflow), 0);
    check({tag, "_udf"}, int'(underflow), 0);
  endtask

  // Monitor: whenever a pop will happen at the next edge, the head must match the scoreboard.
  always @(negedge clk) begin
    if (rst_n && rd_vld && rd_en) begin
      if (sb.size() == 0) begin
        check("pop_unexpected", int'(rd_data), -1);
      end else begin
        check("pop_data", int'(rd_data), int'(sb.pop_front()));
      end
    end
  end

  initial begin
    int n;
    int bad;

    // Reset state.
    #12;
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First word: accepted at the first edge after reset, visible after two more edges.
    drive_wr(8'hA5);
    tick();
    wr_en = 1'b0;
    check("first_level", int'(level), 1);
    check("first_rdvld_t", int'(rd_vld), 0);
    tick();
    check("first_rdvld_t1", int'(rd_vld), 0);
    tick();
    check("first_rdvld_t2", int'(rd_vld), 1);
    check("first_data", int'(rd_data), 8'hA5);
    check("first_ae", int'(almost_empty), 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("first_pop_level", int'(level), 0);
    check("first_pop_rdvld", int'(rd_vld), 0);

    // Underflow: sticky, set beats clear, cleared by err_clr alone.
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("udf_set", int'(underflow), 1);
    check("udf_level", int'(level), 0);
    tick();
    check("udf_hold", int'(underflow), 1);
    rd_en = 1'b1;
    err_clr = 1'b1;
    tick();
    rd_en = 1'b0;
    check("udf_set_priority", int'(underflow), 1);
    tick();
    err_clr = 1'b0;
    check("udf_clear", int'(underflow), 0);

    // Fill to 2048 with 0..255 repeating.
    for (int i = 0; i < 2048; i++) begin
      if (!wr_vld) check("fill_wr_vld", 0, 1);
      drive_wr(i[7:0]);
      tick();
      if (i + 1 == 2039) check("af_at_2039", int'(almost_full), 0);
      if (i + 1 == 2040) check("af_at_2040", int'(almost_full), 1);
      if (i + 1 == 8)    check("ae_at_8", int'(almost_empty), 1);
      if (i + 1 == 9)    check("ae_at_9", int'(almost_empty), 0);
    end
    wr_data = 8'hEE;
    check("full_wr_vld", int'(wr_vld), 0);
    check("full_level", int'(level), 2048);
    check("full_af", int'(almost_full), 1);
    check("full_ae", int'(almost_empty), 0);
    tick();
    check("ovf_set", int'(overflow), 1);
    check("ovf_level", int'(level), 2048);

    // Full with simultaneous pop: write blocked, wr_vld returns after the edge.
    drive_wr(8'hEF);
    rd_en = 1'b1;
    tick();
    wr_en = 1'b0;
    check("full_pop_wr_vld", int'(wr_vld), 1);
    check("full_pop_level", int'(level), 2047);

    // Drain with rd_en held: must be gap-free for all remaining words.
    err_clr = 1'b1;
    n = 0;
    while (rd_vld && n < 3000) begin
      n++;
      tick();
      err_clr = 1'b0;
    end
    rd_en = 1'b0;
    check("drain_count", n, 2047);
    check("drain_level", int'(level), 0);
    check("drain_rd_vld", int'(rd_vld), 0);
    check("ovf_cleared", int'(overflow), 0);
    check("drain_sb_empty", sb.size(), 0);

    // Steady state at level 3 with write+pop every cycle across pointer wrap.
    for (int i = 0; i < 3; i++) begin
      drive_wr(8'(100 + i));
      tick();
    end
    wr_en = 1'b0;
    tick();
    tick();
    check("lvl3_rd_vld", int'(rd_vld), 1);
    check("lvl3_level", int'(level), 3);
    bad = 0;
    rd_en = 1'b1;
    for (int k = 0; k < 5000; k++) begin
      drive_wr(k[7:0]);
      tick();
      if (level != 12'd3 || !rd_vld) bad++;
    end
    wr_en = 1'b0;
    check("lvl3_steady", bad, 0);
    n = 0;
    while (rd_vld && n < 10) begin
      n++;
      tick();
    end
    rd_en = 1'b0;
    check("lvl3_drain", n, 3);
    check("lvl3_sb_empty", sb.size(), 0);

    // Head stability, then reset mid-burst at level 100.
    for (int i = 0; i < 100; i++) begin
      drive_wr(8'(i + 7));
      tick();
    end
    check("burst_level", int'(level), 100);
    check("burst_head", int'(rd_data), 7);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    wr_en = 1'b0;
    sb.delete();
    #2;
    rst_n = 1'b1;
    drive_wr(8'h3C);
    tick();
    wr_en = 1'b0;
    check("post_rst_rdvld_t", int'(rd_vld), 0);
    tick();
    check("post_rst_rdvld_t1", int'(rd_vld), 0);
    tick();
    check("post_rst_rdvld_t2", int'(rd_vld), 1);
    tick();
    tick();
    check("post_rst_stable", int'(rd_data), 8'h3C);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("post_rst_level", int'(level), 0);
    check("end_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_prefetch_param.md
SYNC_FIFO_PREFETCH_PARAM -- requirements
Module: sync_fifo_prefetch_param

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the word width (legal 1..1152).
REQ-002 Parameter DEPTH_WIDTH, default 11, SHALL set capacity to 2^DEPTH_WIDTH words (legal 4..20).
REQ-003 Parameter AF_LEVEL, default 2040, SHALL set the almost_full threshold (legal 1..2^DEPTH_WIDTH).
REQ-004 Parameter AE_LEVEL, default 8, SHALL set the almost_empty threshold (legal 0..2^DEPTH_WIDTH-1).
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 wr_en  in  1  write request.
REQ-008 wr_data  in  DATA_WIDTH  write word.
REQ-009 wr_vld  out  1  FIFO can accept a write this cycle.
REQ-010 rd_en  in  1  pop request for the word on rd_data.
REQ-011 rd_vld  out  1  rd_data holds the valid head word (first-word-fall-through).
REQ-012 rd_data  out  DATA_WIDTH  head word.
REQ-013 level  out  DEPTH_WIDTH+1  words held, all storage stages included.
REQ-014 almost_full / almost_empty  out  1 each  threshold flags.
REQ-015 err_clr  in  1  clears sticky error flags.
REQ-016 overflow / underflow  out  1 each  sticky error flags.

Function
REQ-017 Write accepted iff wr_en=1 and wr_vld=1 at a rising edge; wr_vld SHALL be 1 iff level < 2^DEPTH_WIDTH.
REQ-018 Pop accepted iff rd_en=1 and rd_vld=1; rd_en with rd_vld=0 SHALL have no effect on data.
REQ-019 Storage SHALL be a synchronous-read array (1-cycle read latency) plus prefetch output register; FSM states EMPTY (no head), FETCH (array read in flight), VALID (head in output register).
REQ-020 Transitions: EMPTY->FETCH when array non-empty; FETCH->VALID on next edge; VALID->FETCH on pop with array non-empty; VALID->EMPTY on pop with array empty; VALID holds without pop.
REQ-021 First write into empty FIFO at edge t SHALL give rd_vld=1 with that word after edge t+2.
REQ-022 Once rd_vld=1 and the array is non-empty, sustained rd_en=1 SHALL pop one word per cycle with no rd_vld gaps.
REQ-023 Order SHALL be strictly FIFO; rd_data SHALL be stable while rd_vld=1 and no pop occurs.
REQ-024 level SHALL update registered: +1 write only, -1 pop only, unchanged for simultaneous write and pop.
REQ-025 Full with simultaneous pop: write blocked that cycle (wr_vld was 0); wr_vld rises after the edge.
REQ-026 Empty with simultaneous write: no pop; latency per REQ-021.
REQ-027 Pointers SHALL wrap modulo 2^DEPTH_WIDTH without loss or duplication.
REQ-028 almost_full SHALL equal (level >= AF_LEVEL); almost_empty SHALL equal (level <= AE_LEVEL); both derived from registered level.
REQ-029 overflow SHALL set on wr_en=1 with wr_vld=0; underflow on rd_en=1 with rd_vld=0; each held until err_clr=1, set taking priority over clear in the same cycle.

Reset
REQ-030 rst_n=0 SHALL asynchronously clear pointers, level, FSM to EMPTY, and force wr_vld=1, rd_vld=0, rd_data=0, almost_full=0, almost_empty=1, overflow=0, underflow=0.
REQ-031 Reset mid-operation SHALL discard all stored words; array contents need not be cleared.
REQ-032 First write SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-033 Macro SYNC_FIFO_PF_PARITY_EN defined: array stores DATA_WIDTH+1 bits with even parity; output par_err (1 bit) SHALL pulse for one cycle when a word with bad parity loads into the output register; reset 0.
REQ-034 Macro undefined: array stores DATA_WIDTH bits, port par_err absent, no parity logic.

Verification
REQ-035 Reset, write 0xA5 at edge t -> rd_vld=1, rd_data=0xA5 after edge t+2, level=1, almost_empty=1.
REQ-036 Write 2048 words 0..255 repeating -> wr_vld=0, level=2048, almost_full=1 from level 2040; extra wr_en sets overflow.
REQ-037 Full FIFO, rd_en held 2048 cycles -> data 0..255 repeating, no rd_vld gap, final level=0, rd_vld=0.
REQ-038 Simultaneous write/pop for 5000 cycles at level 3 -> level stays 3, order preserved across pointer wrap.
REQ-039 rd_en on empty -> underflow=1 held; err_clr=1 one cycle -> underflow=0.
REQ-040 rst_n low mid-burst at level 100 -> all outputs per REQ-030 immediately; next write yields rd_vld after 2 edges.
